// File: rtl/demux_2x4.sv
// Registered 1-to-4 demultiplexer with one-hot valid strobe and
// per-channel saturating route counters.
module demux_2x4 #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    input  logic [1:0]        sel,
    input  logic              en,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y3,
    output logic [3:0]        vld,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
);

    // vld is a pure one-cycle strobe (no handshake): bit k high means channel k
    // was routed on the last edge, independent of the data value carried.
    logic [3:0]       route;
    logic [CNT_W-1:0] cnt_q [4];

    always_comb begin
        route = 4'b0000;
        if (en) begin
            route = 4'b0001 << sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0  <= '0;
            y1  <= '0;
            y2  <= '0;
            y3  <= '0;
            vld <= 4'b0000;
        end else begin
            y0  <= route[0] ? in : '0;
            y1  <= route[1] ? in : '0;
            y2  <= route[2] ? in : '0;
            y3  <= route[3] ? in : '0;
            vld <= route;
        end
    end

    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (clr_cnt) begin
                    cnt_q[k] <= '0;
                end else if (route[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux_2x4.sv
// Directed bench for demux_2x4: an 8-bit/8-bit-counter instance for routing,
// clear and reset, and a 1-bit/2-bit-counter instance for saturation.
module tb_demux_2x4;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       din_s;
    logic [1:0] sel;
    logic       en;
    logic       clr_cnt;

    logic [7:0] y0, y1, y2, y3;
    logic [3:0] vld;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;

    logic       sy0, sy1, sy2, sy3;
    logic [3:0] svld;
    logic [1:0] scnt0, scnt1, scnt2, scnt3;

    int n_tests;
    int n_fail;

    assign din_s = din[0];

    demux_2x4 #(.DATA_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in(din), .sel(sel), .en(en), .clr_cnt(clr_cnt),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .vld(vld),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    demux_2x4 #(.DATA_W(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in(din_s), .sel(sel), .en(en), .clr_cnt(clr_cnt),
        .y0(sy0), .y1(sy1), .y2(sy2), .y3(sy3), .vld(svld),
        .cnt0(scnt0), .cnt1(scnt1), .cnt2(scnt2), .cnt3(scnt3)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: apply inputs, take one rising edge, settle away from it
    task automatic step(input logic [7:0] i, input logic [1:0] s, input logic e, input logic c);
        din     = i;
        sel     = s;
        en      = e;
        clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_y(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] ev);
        check({tag, ".y0"}, 32'(y0), 32'(e0));
        check({tag, ".y1"}, 32'(y1), 32'(e1));
        check({tag, ".y2"}, 32'(y2), 32'(e2));
        check({tag, ".y3"}, 32'(y3), 32'(e3));
        check({tag, ".vld"}, 32'(vld), 32'(ev));
    endtask

    task automatic check_cnt(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        check({tag, ".cnt0"}, 32'(cnt0), 32'(e0));
        check({tag, ".cnt1"}, 32'(cnt1), 32'(e1));
        check({tag, ".cnt2"}, 32'(cnt2), 32'(e2));
        check({tag, ".cnt3"}, 32'(cnt3), 32'(e3));
    endtask

    logic [3:0] sweep_vld [4];
    logic [1:0] sat_seq   [5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sweep_vld[0] = 4'b0001; sweep_vld[1] = 4'b0010;
        sweep_vld[2] = 4'b0100; sweep_vld[3] = 4'b1000;
        sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3;
        sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;

        // reset state, with active-looking inputs held
        rst_n = 1'b0; din = 8'hFF; sel = 2'd2; en = 1'b1; clr_cnt = 1'b0;
        #3;
        check_y("reset", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        check_cnt("reset", 8'd0, 8'd0, 8'd0, 8'd0);
        @(posedge clk); #1;
        check_y("reset_hold", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        check("reset_hold.scnt2", 32'(scnt2), 32'd0);
        #2 rst_n = 1'b1;

        // sweep sel with in=1
        for (int s = 0; s < 4; s++) begin
            step(8'h01, 2'(s), 1'b1, 1'b0);
            check_y($sformatf("sweep%0d", s),
                    (s == 0) ? 8'h01 : 8'h00, (s == 1) ? 8'h01 : 8'h00,
                    (s == 2) ? 8'h01 : 8'h00, (s == 3) ? 8'h01 : 8'h00, sweep_vld[s]);
            check($sformatf("sweep%0d.svld", s), 32'(svld), 32'(sweep_vld[s]));
        end
        check_cnt("sweep", 8'd1, 8'd1, 8'd1, 8'd1);

        // enable gate
        for (int i = 0; i < 3; i++) begin
            step(8'h01, 2'd2, 1'b0, 1'b0);
            check_y($sformatf("gate%0d", i), 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
            check($sformatf("gate%0d.cnt2", i), 32'(cnt2), 32'd1);
        end

        // full data width, then in=0 still strobes vld
        step(8'hA5, 2'd2, 1'b1, 1'b0);
        check_y("width", 8'h00, 8'h00, 8'hA5, 8'h00, 4'b0100);
        check("width.cnt2", 32'(cnt2), 32'd2);
        step(8'h00, 2'd0, 1'b1, 1'b0);
        check_y("zero_data", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);
        check("zero_data.cnt0", 32'(cnt0), 32'd2);

        // clear priority over increment; clear leaves routing alone
        step(8'h5A, 2'd3, 1'b1, 1'b0);
        check("pre_clr.cnt3", 32'(cnt3), 32'd2);
        step(8'h3C, 2'd3, 1'b1, 1'b1);
        check_y("clr", 8'h00, 8'h00, 8'h00, 8'h3C, 4'b1000);
        check_cnt("clr", 8'd0, 8'd0, 8'd0, 8'd0);
        check("clr.scnt3", 32'(scnt3), 32'd0);

        // saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) begin
            step(8'h01, 2'd1, 1'b1, 1'b0);
            check($sformatf("sat%0d.scnt1", i), 32'(scnt1), 32'(sat_seq[i]));
            check($sformatf("sat%0d.sy1", i), 32'(sy1), 32'd1);
            check($sformatf("sat%0d.cnt1", i), 32'(cnt1), 32'(i + 1));
        end
        check("sat.scnt0", 32'(scnt0), 32'd0);
        check("sat.scnt2", 32'(scnt2), 32'd0);
        check("sat.scnt3", 32'(scnt3), 32'd0);

        // async reset mid-cycle with y1=1, cnt1=4
        step(8'h00, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(8'h01, 2'd1, 1'b1, 1'b0);
        end
        check("pre_rst.y1", 32'(y1), 32'd1);
        check("pre_rst.cnt1", 32'(cnt1), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("async.y1", 32'(y1), 32'd0);
        check("async.vld", 32'(vld), 32'd0);
        check("async.cnt1", 32'(cnt1), 32'd0);
        #3 rst_n = 1'b1;
        step(8'h01, 2'd0, 1'b1, 1'b0);
        check_y("resume", 8'h01, 8'h00, 8'h00, 8'h00, 4'b0001);
        check_cnt("resume", 8'd1, 8'd0, 8'd0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
